autocat_partition_ctrl: RTL and testbench

//  Epoch sequencer for the autocat hit-counter/sorter datapath. Counts cache accesses
//  per epoch, then waits out the sorter pipeline, snapshots the sorted per-way hit

---
 rtl/autocat_partition_ctrl_if.sv | 19 +
 rtl/autocat_partition_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_autocat_partition_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/autocat_partition_ctrl_if.sv
// Waymask offer channel between the autocat epoch sequencer and the cache
// way-partition register. The sequencer drives mask/valid, the cache drives ready.
interface autocat_partition_ctrl_if;
  logic [15:0] waymask_out;
  logic        waymask_valid_out;
  logic        waymask_ready_in;

  modport master (
    output waymask_out,
    output waymask_valid_out,
    input  waymask_ready_in
  );

  modport slave (
    input  waymask_out,
    input  waymask_valid_out,
    output waymask_ready_in
  );
endinterface

// File: rtl/autocat_partition_ctrl.sv
// autocat epoch sequencer: counts accesses per epoch, waits out the sorter pipeline,
// snapshots and clears the hit counters, sums the snapshot, then walks it serially to
// find the fewest leading (largest) ways covering the hit target, and offers the
// resulting contiguous waymask through a valid/ready handshake.
module autocat_partition_ctrl #(
  parameter int CACHE_ASSOCIATIVITY = 16,
  parameter int COUNTER_WIDTH       = 32,
  parameter int EPOCH_POWER         = 20,
  parameter int SORTER_LATENCY      = 10,
  parameter int THRESHOLD_SHIFT     = 3,
  parameter int MIN_WAYS            = 1
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic                                         access_valid_in,
  input  logic [CACHE_ASSOCIATIVITY*COUNTER_WIDTH-1:0] sorted_counter_flatted_in,
  output logic                                         counter_clear_out,
  autocat_partition_ctrl_if.master                     wm_if,
  output logic                                         busy_out,
  output logic [15:0]                                  epoch_count_out
);

  localparam int WAYS   = CACHE_ASSOCIATIVITY;
  localparam int CW     = COUNTER_WIDTH;
  localparam int TW     = COUNTER_WIDTH + 4;   // 16 slices summed cannot overflow
  localparam int ACC_W  = EPOCH_POWER + 1;
  localparam int WAIT_W = $clog2(SORTER_LATENCY + 2);

  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'((64'd1 << EPOCH_POWER) - 64'd1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SORTER_LATENCY);
  localparam logic [3:0]        IDX_LAST  = 4'(WAYS - 1);
  localparam logic [4:0]        MIN_W     = 5'(MIN_WAYS);

  typedef enum logic [2:0] {
    ST_COUNT  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SUM    = 3'd2,
    ST_SELECT = 3'd3,
    ST_ISSUE  = 3'd4
  } state_t;

  // Contiguous mask with the low 'ways' bits set; ways = 16 yields all ones.
  function automatic logic [15:0] mask_of(input logic [4:0] ways);
    logic [16:0] m;
    m = (17'd1 << ways) - 17'd1;
    return m[15:0];
  endfunction

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        idx_q, idx_d;
  logic [TW-1:0]     total_q, total_d;
  logic [TW-1:0]     target_q, target_d;
  logic [TW-1:0]     cum_q, cum_d;
  logic              clear_q, clear_d;
  logic [15:0]       mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [15:0]       epoch_q, epoch_d;
  logic              snap_load_s;
  logic [CW-1:0]     snap_q [WAYS];

  logic [CW-1:0]     cur_slice_s;
  logic [TW-1:0]     sum_next_s;
  logic [TW-1:0]     cum_next_s;
  logic [4:0]        ways_idx_s;
  logic [4:0]        ways_sel_s;

  // The serial walk (both summing and selecting) reads one snapshot slice per cycle.
  assign cur_slice_s = snap_q[idx_q];
  assign sum_next_s  = total_q + TW'(cur_slice_s);
  assign cum_next_s  = cum_q + TW'(cur_slice_s);
  assign ways_idx_s  = {1'b0, idx_q} + 5'd1;
  assign ways_sel_s  = (ways_idx_s < MIN_W) ? MIN_W : ways_idx_s;

  // Next-state and datapath control for the epoch sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    total_d     = total_q;
    target_d    = target_q;
    cum_d       = cum_q;
    clear_d     = 1'b0;
    mask_d      = mask_q;
    valid_d     = valid_q;
    epoch_d     = epoch_q;
    snap_load_s = 1'b0;

    case (state_q)
      ST_COUNT: begin
        if (access_valid_in) begin
          if (acc_q == ACC_LAST) begin
            acc_d   = {ACC_W{1'b0}};
            wait_d  = {WAIT_W{1'b0}};
            state_d = ST_WAIT;
          end else begin
            acc_d = acc_q + ACC_W'(1);
          end
        end else begin
          acc_d = acc_q;
        end
      end

      ST_WAIT: begin
        // Last waiting cycle: the sorter output now reflects every counted access.
        if (wait_q == WAIT_LAST) begin
          snap_load_s = 1'b1;
          clear_d     = 1'b1;
          total_d     = {TW{1'b0}};
          idx_d       = 4'd0;
          state_d     = ST_SUM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_SUM: begin
        total_d = sum_next_s;
        if (idx_q == IDX_LAST) begin
          target_d = sum_next_s - (sum_next_s >> THRESHOLD_SHIFT);
          idx_d    = 4'd0;
          cum_d    = {TW{1'b0}};
          state_d  = ST_SELECT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_SELECT: begin
        // With no hits at all there is nothing to cover; grant the minimum at once.
        if (total_q == {TW{1'b0}}) begin
          mask_d  = mask_of(MIN_W);
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          cum_d = cum_next_s;
          if ((cum_next_s >= target_q) || (idx_q == IDX_LAST)) begin
            mask_d  = mask_of(ways_sel_s);
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_ISSUE: begin
        if (wm_if.waymask_ready_in) begin
          valid_d = 1'b0;
          epoch_d = epoch_q + 16'd1;
          acc_d   = {ACC_W{1'b0}};
          state_d = ST_COUNT;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_COUNT;
        acc_d   = {ACC_W{1'b0}};
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_COUNT);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= ST_COUNT;
      acc_q    <= {ACC_W{1'b0}};
      wait_q   <= {WAIT_W{1'b0}};
      idx_q    <= 4'd0;
      total_q  <= {TW{1'b0}};
      target_q <= {TW{1'b0}};
      cum_q    <= {TW{1'b0}};
      clear_q  <= 1'b0;
      mask_q   <= 16'hFFFF;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      epoch_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      total_q  <= total_d;
      target_q <= target_d;
      cum_q    <= cum_d;
      clear_q  <= clear_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      epoch_q  <= epoch_d;
    end
  end

  // Snapshot of the sorted counters, captured just before they are cleared.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < WAYS; i++) begin
        snap_q[i] <= {CW{1'b0}};
      end
    end else if (snap_load_s) begin
      for (int i = 0; i < WAYS; i++) begin
        snap_q[i] <= sorted_counter_flatted_in[i*CW +: CW];
      end
    end
  end

  assign counter_clear_out       = clear_q;
  assign wm_if.waymask_out       = mask_q;
  assign wm_if.waymask_valid_out = valid_q;
  assign busy_out                = busy_q;
  assign epoch_count_out         = epoch_q;

endmodule

// File: tb/tb_autocat_partition_ctrl.sv
// Bench for autocat_partition_ctrl with a short epoch (16 accesses) and a 2-cycle
// sorter. Directed vectors from a table, hand sequences for handshake stall and
// mid-epoch reset, and random hit profiles checked against a coverage model.
module tb_autocat_partition_ctrl;

  logic              clk_in = 1'b0;
  logic              reset_in = 1'b1;
  logic              access_valid_in = 1'b0;
  logic [15:0][31:0] sorted_in = '0;
  logic              counter_clear_out;
  logic              busy_out;
  logic [15:0]       epoch_count_out;

  autocat_partition_ctrl_if wm_if ();

  int n_cmp = 0;
  int n_mis = 0;

  autocat_partition_ctrl #(
    .CACHE_ASSOCIATIVITY(16),
    .COUNTER_WIDTH(32),
    .EPOCH_POWER(4),
    .SORTER_LATENCY(2),
    .THRESHOLD_SHIFT(3),
    .MIN_WAYS(1)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .access_valid_in(access_valid_in),
    .sorted_counter_flatted_in(sorted_in),
    .counter_clear_out(counter_clear_out),
    .wm_if(wm_if),
    .busy_out(busy_out),
    .epoch_count_out(epoch_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0][31:0] s;
    logic [15:0]       mask;
    int                lat;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Coverage model: fewest leading ways whose hits reach total - total/8.
  // sel is the number of cycles the serial selection needs to decide.
  function automatic void ref_model(input logic [15:0][31:0] s, output logic [15:0] mask,
                                    output int sel);
    longint total = 0;
    longint target;
    longint cum = 0;
    int ways;
    for (int i = 0; i < 16; i++) total += longint'(s[i]);
    target = total - total / 8;
    if (total == 0) begin
      ways = 1;
      sel  = 1;
    end else begin
      ways = 16;
      sel  = 16;
      for (int i = 0; i < 16; i++) begin
        cum += longint'(s[i]);
        if (cum >= target) begin
          ways = i + 1;
          sel  = i + 1;
          break;
        end
      end
    end
    if (ways < 1) ways = 1;
    mask = 16'h0000;
    for (int i = 0; i < ways; i++) mask[i] = 1'b1;
  endfunction

  // Called right after the edge that counted the last access of an epoch.
  task automatic finish_epoch(input logic [15:0] emask, input int elat, input string tag);
    int n = 0;
    int clears = 0;
    int clr_at = -1;
    logic [15:0] e0;
    check({tag, "_busy_rise"}, 64'(busy_out), 64'd1);
    while (wm_if.waymask_valid_out !== 1'b1 && n < 60) begin
      step();
      n++;
      if (counter_clear_out === 1'b1) begin
        clears++;
        if (clr_at < 0) clr_at = n;
      end
    end
    check({tag, "_valid_seen"}, 64'(wm_if.waymask_valid_out), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(elat));
    check({tag, "_clear_count"}, 64'(clears), 64'd1);
    check({tag, "_clear_at"}, 64'(clr_at), 64'd3);
    check({tag, "_mask"}, 64'(wm_if.waymask_out), 64'(emask));
    e0 = epoch_count_out;
    wm_if.waymask_ready_in = 1'b1;
    step();
    check({tag, "_valid_drop"}, 64'(wm_if.waymask_valid_out), 64'd0);
    check({tag, "_epoch_inc"}, 64'(epoch_count_out), 64'(e0 + 16'd1));
    check({tag, "_back_count"}, 64'(busy_out), 64'd0);
    check({tag, "_mask_hold"}, 64'(wm_if.waymask_out), 64'(emask));
  endtask

  task automatic run_epoch(input logic [15:0][31:0] s, input logic [15:0] emask,
                           input int elat, input string tag);
    sorted_in = s;
    access_valid_in = 1'b1;
    repeat (16) step();
    access_valid_in = 1'b0;
    finish_epoch(emask, elat, tag);
  endtask

  initial begin
    logic [15:0][31:0] s;
    logic [15:0] m;
    logic [15:0] e0;
    int sel;
    int acc;
    int q[$];

    // Directed hit profiles; latency = 3 wait + 16 sum + selection cycles.
    s = '0; s[0] = 32'd100; s[1] = 32'd50; s[2] = 32'd30; s[3] = 32'd20;
    tbl[0].s = s; tbl[0].mask = 16'h0007; tbl[0].lat = 22;
    s = '0; for (int i = 0; i < 16; i++) s[i] = 32'd10;
    tbl[1].s = s; tbl[1].mask = 16'h3FFF; tbl[1].lat = 33;
    s = '0;
    tbl[2].s = s; tbl[2].mask = 16'h0001; tbl[2].lat = 20;
    s = '0; s[0] = 32'd1000;
    tbl[3].s = s; tbl[3].mask = 16'h0001; tbl[3].lat = 20;

    wm_if.waymask_ready_in = 1'b0;
    reset_in = 1'b1;
    step();
    step();
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_clear", 64'(counter_clear_out), 64'd0);
    check("rst_mask", 64'(wm_if.waymask_out), 64'hFFFF);
    check("rst_valid", 64'(wm_if.waymask_valid_out), 64'd0);
    check("rst_epoch", 64'(epoch_count_out), 64'd0);
    reset_in = 1'b0;
    step();

    // A 15-access epoch must not close; the 16th access closes it.
    sorted_in = tbl[0].s;
    access_valid_in = 1'b1;
    repeat (15) step();
    access_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("short_epoch_busy", 64'(busy_out), 64'd0);
      check("short_epoch_clear", 64'(counter_clear_out), 64'd0);
    end
    access_valid_in = 1'b1;
    step();
    access_valid_in = 1'b0;
    finish_epoch(tbl[0].mask, tbl[0].lat, "close");

    for (int i = 0; i < 4; i++) begin
      run_epoch(tbl[i].s, tbl[i].mask, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // Handshake stall: mask/valid stable, epoch frozen, accesses ignored.
    wm_if.waymask_ready_in = 1'b0;
    sorted_in = tbl[1].s;
    access_valid_in = 1'b1;
    repeat (16) step();
    begin
      int n = 0;
      while (wm_if.waymask_valid_out !== 1'b1 && n < 60) begin
        step();
        n++;
      end
      check("hs_valid_seen", 64'(wm_if.waymask_valid_out), 64'd1);
    end
    e0 = epoch_count_out;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hs_stall_mask", 64'(wm_if.waymask_out), 64'h3FFF);
      check("hs_stall_valid", 64'(wm_if.waymask_valid_out), 64'd1);
      check("hs_stall_epoch", 64'(epoch_count_out), 64'(e0));
    end
    wm_if.waymask_ready_in = 1'b1;
    step();
    access_valid_in = 1'b0;
    check("hs_valid_drop", 64'(wm_if.waymask_valid_out), 64'd0);
    check("hs_epoch_inc", 64'(epoch_count_out), 64'(e0 + 16'd1));
    check("hs_back_count", 64'(busy_out), 64'd0);
    step();
    check("hs_single_xfer", 64'(epoch_count_out), 64'(e0 + 16'd1));
    access_valid_in = 1'b1;
    repeat (15) step();
    access_valid_in = 1'b0;
    step();
    check("hs_fresh_count", 64'(busy_out), 64'd0);
    access_valid_in = 1'b1;
    step();
    access_valid_in = 1'b0;
    finish_epoch(16'h3FFF, 33, "hs_next");

    // Random sorted hit profiles with sparse access patterns.
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(0);
        else q.push_back(int'($urandom_range(0, 500)));
      end
      if (r == 7) begin
        for (int i = 0; i < 16; i++) q[i] = 0;
        q[0] = 7;
      end
      q.rsort();
      for (int i = 0; i < 16; i++) s[i] = 32'(q[i]);
      ref_model(s, m, sel);
      sorted_in = s;
      acc = 0;
      while (acc < 16) begin
        access_valid_in = ($urandom_range(0, 1) == 1);
        if (access_valid_in) acc++;
        step();
        if (acc < 16) check("rnd_busy_low", 64'(busy_out), 64'd0);
      end
      access_valid_in = 1'b0;
      finish_epoch(m, 19 + sel, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of SUM discards the epoch.
    run_epoch(tbl[0].s, tbl[0].mask, tbl[0].lat, "pre_rst");
    sorted_in = tbl[1].s;
    access_valid_in = 1'b1;
    repeat (16) step();
    access_valid_in = 1'b0;
    repeat (8) step();
    check("mid_sum_busy", 64'(busy_out), 64'd1);
    reset_in = 1'b1;
    #1;
    check("arst_busy", 64'(busy_out), 64'd0);
    check("arst_clear", 64'(counter_clear_out), 64'd0);
    check("arst_mask", 64'(wm_if.waymask_out), 64'hFFFF);
    check("arst_valid", 64'(wm_if.waymask_valid_out), 64'd0);
    check("arst_epoch", 64'(epoch_count_out), 64'd0);
    step();
    reset_in = 1'b0;
    sorted_in = tbl[0].s;
    access_valid_in = 1'b1;
    repeat (15) step();
    access_valid_in = 1'b0;
    step();
    check("arst_fresh_count", 64'(busy_out), 64'd0);
    access_valid_in = 1'b1;
    step();
    access_valid_in = 1'b0;
    finish_epoch(tbl[0].mask, tbl[0].lat, "post_rst");
    check("post_rst_epoch", 64'(epoch_count_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
